// File: rtl/cordic_vector_arbiter.sv
// Round-robin front end sharing one pipelined CORDIC vectoring unit among NREQ requesters.
// Requester IDs ride a tag shift register matched to the datapath latency.
module cordic_vector_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int PIPE_LAT = 34
) (
  input  logic                 clk,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x,
  input  logic [NREQ*32-1:0]   req_y,
  input  logic [NREQ*32-1:0]   req_z,
  input  logic [NREQ-1:0]      req_mask,
  input  logic                 flush,
  output logic [31:0]          cord_x,
  output logic [31:0]          cord_y,
  output logic [31:0]          cord_z,
  input  logic [31:0]          cord_xn,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          res_data,
  output logic [7:0]           inflight,
  output logic                 busy
);

  logic [NREQ-1:0] eligible;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_found;
  logic [IDW:0]    cand;
  logic            fire;
  logic            retire;
  logic [31:0]     sel_x, sel_y, sel_z;
  logic [PIPE_LAT:0] tag_v;
  logic [IDW-1:0]  tag_id [0:PIPE_LAT];

  // Search starts one past the last winner and wraps modulo NREQ.
  always_comb begin
    eligible    = req_valid & ~req_mask & {NREQ{~flush}};
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && eligible[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign fire   = |(req_valid & req_ready);
  assign retire = tag_v[PIPE_LAT];

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_z = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_x = req_x[32*i +: 32];
        sel_y = req_y[32*i +: 32];
        sel_z = req_z[32*i +: 32];
      end
    end
  end

  // Idle cycles drive zero operands so the pipeline carries no stale data.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      cord_x     <= '0;
      cord_y     <= '0;
      cord_z     <= '0;
      last_grant <= IDW'(NREQ-1);
    end else begin
      cord_x <= sel_x;
      cord_y <= sel_y;
      cord_z <= sel_z;
      if (fire) last_grant <= grant_idx;
    end
  end

  // Flush drops every valid bit; the IDs can keep shifting harmlessly.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      tag_v <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v     <= flush ? '0 : {tag_v[PIPE_LAT-1:0], fire};
      tag_id[0] <= grant_idx;
      for (int i = 1; i <= PIPE_LAT; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else if (fire && !retire) begin
      inflight <= inflight + 8'd1;
    end else if (!fire && retire) begin
      inflight <= inflight - 8'd1;
    end
  end

  assign res_valid = tag_v[PIPE_LAT];
  assign res_id    = tag_id[PIPE_LAT];
  assign res_data  = cord_xn;
  assign busy      = (inflight != 8'd0);

endmodule

// File: doc/cordic_vector_arbiter.md
# cordic_vector_arbiter

Shares one fully pipelined CORDIC vectoring unit among `NREQ` requesters. Each cycle a round-robin arbiter grants at most one requester. The granted operands are registered onto the CORDIC inputs, and the requester ID travels down a tag shift register matched to the datapath latency. When a result emerges, it is returned on a single result bus tagged with the originating ID. The block sits between the requester fabric (magnitude/normalisation clients) and the CORDIC vector pipeline.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, 2: width of the requester ID, equal to clog2(`NREQ`).
- `PIPE_LAT`, 34: clock edges from operand capture to a valid CORDIC `Output_xn` (input register, 32 rotation stages, output register). Legal range 2..254.
- `clk`  in  1  clock.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero.
- `req_x`, `req_y`, `req_z`  in  NREQ*32  packed signed Q16.16 operands; requester i occupies bits [32i+31:32i].
- `req_mask`  in  NREQ  1 = requester disabled, never granted.
- `flush`  in  1  synchronous kill of all in-flight tags.
- `cord_x`, `cord_y`, `cord_z`  out  32 each  operands to the CORDIC `Input_x`/`Input_y`/`Input_z`.
- `cord_xn`  in  32  CORDIC `Output_xn`.
- `res_valid`  out  1  result strobe; no backpressure.
- `res_id`  out  IDW  ID of the requester that issued this result.
- `res_data`  out  32  result, taken directly from `cord_xn`.
- `inflight`  out  8  number of issued operations not yet retired.
- `busy`  out  1  high when `inflight` != 0.

## Operation
- **Eligibility:** requester i is eligible when `req_valid[i]` is high, `req_mask[i]` is low and `flush` is low.
- **Arbitration:** round-robin. The search starts at `last_grant`+1, modulo `NREQ`, and takes the first eligible requester. `req_ready[g]` is combinational and depends on `req_valid`; requesters must not wait for `req_ready` before raising `req_valid`.
- **Fire:** `req_valid[g]` & `req_ready[g]`.
  - On a fire, `cord_x/y/z` register `req_x/y/z` slice g.
  - On a fire, `last_grant` <= g.
  - On a cycle with no fire, `cord_x/y/z` <= 0 and `last_grant` holds.
- **Tag chain:** a shift register of `PIPE_LAT`+1 entries {v, id} that shifts every cycle.
  - Entry[0] <= {fire, g}.
  - `res_valid` = entry[`PIPE_LAT`].v and `res_id` = entry[`PIPE_LAT`].id.
  - `res_data` = `cord_xn`, passed combinationally.
- **`flush`:** clears every v bit on the next edge, including the entry[0] load (no fire occurs while `flush` is high). `inflight` <= 0. The CORDIC pipeline keeps running, but its outputs are ignored because no valid tags remain.
- **`inflight`:** +1 on a fire edge; −1 on an edge where a valid tag leaves entry[`PIPE_LAT`]. When both happen on the same edge, the count is unchanged.
- **`req_mask` change:** takes effect in the same cycle's arbitration. Operations already issued still complete and return.
- **Reset:** asynchronous assertion clears everything regardless of in-flight work. After deassertion there are no stale results.

## Timing
- **Reset values:** `req_ready`=0, `cord_x/y/z`=0, `res_valid`=0, `res_id`=0, `inflight`=0, `busy`=0, `last_grant`=`NREQ`-1, so requester 0 is searched first.
- **Latency:** for a fire at edge E0, `cord_*` update at E0. `res_valid` is high for exactly one cycle, following edge E0+`PIPE_LAT`, aligned with the `cord_xn` value for that operand.
- **Throughput:** one issue per cycle. With continuous issue, `inflight` settles at `PIPE_LAT`+1 (35 at the default).
- **Ordering:** results return in issue order. There is no reordering and no per-requester limit; consumers must accept `res_valid` in every cycle.
- **`flush` and reset:** a `flush` high at edge Ef suppresses every result whose issue edge is ≤ Ef. An operation that fires at Ef+1 returns normally at Ef+1+`PIPE_LAT`.

## Test plan
- **Single request:** after reset, requester 2 presents x=0x00030000, y=0x00040000, z=0 for one cycle.
  - Required: `req_ready`=0100; `cord_x`=0x00030000 after that edge.
  - Required: 34 edges later, `res_valid`=1, `res_id`=2, `res_data`=`cord_xn` (≈0x00050000 from the real CORDIC).
- **Round-robin:** all four requesters hold `req_valid` for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: `res_id` sequence identical, starting 34 cycles later, with no gaps.
  - Required: `inflight` reaches 8, then counts down to 0.
- **Mask:** `req_mask`=0010 with all requesters valid. Required: grants cycle 0,2,3 and `req_ready[1]` is never asserted.
- **Flush mid-flight:** issue 5 operations, then assert `flush` for 1 cycle 10 cycles later.
  - Required: no `res_valid` for any of those 5 operations; `inflight`=0 after the flush edge.
  - Required: a subsequent issue returns after 34 cycles.
- **Reset mid-operation:** pulse `RST_N` low asynchronously, between edges, with 20 operations in flight.
  - Required: all outputs go to reset values immediately; no `res_valid` afterwards.
  - Required: after release, the first grant goes to requester 0.
- **Saturation with `PIPE_LAT`=4:** continuous requests from requester 3 only.
  - Required: `req_ready[3]` is high in every cycle.
  - Required: `inflight` steady at 5, `busy`=1, and `res_valid` continuous from cycle 5 on.
